// File: rtl/lpc.sv
// lpc: passive LPC bus sniffer; decodes I/O and memory read/write cycles
// and presents each completed cycle with a one-clock valid strobe.
module lpc (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [3:0]  lpc_ad,
    input  logic        lpc_frame,
    output logic [3:0]  out_cyctype_dir,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [3:0]  out_data_size,
    output logic        out_clock_enable
);
    typedef enum logic [3:0] {IDLE, START, CYCTYPE, ADDR, WDATA, TAR1, SYNC, RDATA, TAR2} state_t;
    state_t      state, state_nx;
    logic [3:0]  ctdir, ctdir_nx;
    logic [31:0] addr, addr_nx;
    logic [7:0]  data, data_nx;
    logic [2:0]  cnt;
    logic        strobe;
    logic        is_write;
    logic [2:0]  last;
    assign is_write = ctdir[1];
    assign last     = ctdir[2] ? 3'd7 : 3'd3;
    always_comb begin
        state_nx = state;
        ctdir_nx = ctdir;
        addr_nx  = addr;
        data_nx  = data;
        strobe   = 1'b0;
        case (state)
            IDLE: state_nx = (!lpc_frame && lpc_ad == 4'h0) ? START : IDLE;
            START: begin
                addr_nx = '0;
                data_nx = '0;
                if (lpc_frame) begin
                    ctdir_nx = lpc_ad;
                    state_nx = lpc_ad[3] ? IDLE : ADDR;
                end else if (lpc_ad != 4'h0) begin
                    state_nx = IDLE;
                end
            end
            ADDR: begin
                addr_nx = {addr[27:0], lpc_ad};
                if (cnt == last) state_nx = is_write ? WDATA : TAR1;
            end
            WDATA, RDATA: begin
                data_nx = cnt[0] ? {lpc_ad, data[3:0]} : {data[7:4], lpc_ad};
                if (cnt[0]) begin
                    state_nx = (state == WDATA) ? TAR1 : TAR2;
                    strobe   = (state == RDATA);
                end
            end
            TAR1, TAR2: if (cnt[0]) state_nx = (state == TAR1) ? SYNC : IDLE;
            SYNC: begin
                if (lpc_ad == 4'h0) begin
                    state_nx = is_write ? TAR2 : RDATA;
                    strobe   = is_write;
                end else if (lpc_ad != 4'h5 && lpc_ad != 4'h6) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // LFRAME# low mid-cycle aborts; a 0000 nibble also opens a new start field
        if (state != IDLE && state != START && !lpc_frame) begin
            state_nx = (lpc_ad == 4'h0) ? START : IDLE;
            strobe   = 1'b0;
        end
    end
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state            <= IDLE;
            ctdir            <= '0;
            addr             <= '0;
            data             <= '0;
            cnt              <= '0;
            out_cyctype_dir  <= '0;
            out_addr         <= '0;
            out_data         <= '0;
            out_data_size    <= '0;
            out_clock_enable <= 1'b0;
        end else begin
            state            <= state_nx;
            ctdir            <= ctdir_nx;
            addr             <= addr_nx;
            data             <= data_nx;
            cnt              <= (state_nx == state) ? cnt + 3'd1 : 3'd0;
            out_clock_enable <= strobe;
            if (strobe) begin
                out_cyctype_dir <= ctdir;
                out_addr        <= addr;
                out_data        <= {24'h0, data_nx};
                out_data_size   <= 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_lpc.sv
// tb_lpc: drives LPC cycles from a transaction description and checks the
// sniffer against a transaction-level model of the expected captures.
module tb_lpc;
    logic        lpc_clock = 1'b0;
    logic        lpc_reset;
    logic [3:0]  lpc_ad = 4'h0;
    logic        lpc_frame = 1'b1;
    logic [3:0]  out_cyctype_dir;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  out_data_size;
    logic        out_clock_enable;

    lpc dut (
        .lpc_clock(lpc_clock),
        .lpc_reset(lpc_reset),
        .lpc_ad(lpc_ad),
        .lpc_frame(lpc_frame),
        .out_cyctype_dir(out_cyctype_dir),
        .out_addr(out_addr),
        .out_data(out_data),
        .out_data_size(out_data_size),
        .out_clock_enable(out_clock_enable)
    );

    always #15 lpc_clock = ~lpc_clock;

    int passed = 0, total = 0;
    int strobes = 0, exp_strobes = 0;
    logic [3:0]  exp_ct = '0, exp_size = '0;
    logic [31:0] exp_addr = '0, exp_data = '0;
    logic [71:0] obs, expv;
    assign obs  = {out_cyctype_dir, out_addr, out_data, out_data_size};
    assign expv = {exp_ct, exp_addr, exp_data, exp_size};

    // strobe-high cycles; a stuck or doubled strobe shows up as an extra count
    always @(negedge lpc_clock) if (out_clock_enable === 1'b1) strobes++;

    task automatic drive(input logic f, input logic [3:0] a);
        @(negedge lpc_clock);
        lpc_frame = f;
        lpc_ad = a;
    endtask

    // One LPC cycle. abort_at >= 0 pulls LFRAME# low with abort_ad in place of that address nibble.
    task automatic send(input logic mem, input logic wr, input logic rsv, input logic [31:0] a,
                        input logic [7:0] d, input int waits, input logic err, input int abort_at,
                        input logic [3:0] abort_ad, input logic skip_start, input int idles);
        logic [3:0] ct;
        int n;
        bit aborted;
        ct = {1'b0, mem, wr, rsv};
        n = mem ? 8 : 4;
        aborted = 0;
        if (!skip_start) drive(1'b0, 4'h0);
        drive(1'b1, ct);
        for (int i = 0; i < n && !aborted; i++) begin
            if (i == abort_at) begin
                drive(1'b0, abort_ad);
                aborted = 1;
            end else begin
                drive(1'b1, a[4*(n-1-i) +: 4]);
            end
        end
        if (!aborted) begin
            if (wr) begin drive(1'b1, d[3:0]); drive(1'b1, d[7:4]); end
            repeat (2) drive(1'b1, 4'($urandom));
            repeat (waits) drive(1'b1, $urandom_range(0, 1) ? 4'h5 : 4'h6);
            drive(1'b1, err ? 4'ha : 4'h0);
            if (!err) begin
                if (!wr) begin drive(1'b1, d[3:0]); drive(1'b1, d[7:4]); end
                repeat (2) drive(1'b1, 4'($urandom));
                exp_strobes++;
                exp_ct   = ct;
                exp_addr = mem ? a : {16'h0, a[15:0]};
                exp_data = {24'h0, d};
                exp_size = 4'd1;
            end
        end
        repeat (idles) drive(1'b1, 4'($urandom));
    endtask

    task automatic test_reset;
        #1 lpc_reset = 1'b0;
        repeat (2) @(posedge lpc_clock);
        #2;
        total++;
        if (obs !== 72'h0) $display("FAIL reset_outputs got %h want %h", obs, 72'h0); else passed++;
        total++;
        if (out_clock_enable !== 1'b0) $display("FAIL reset_strobe got %b want 0", out_clock_enable); else passed++;
        @(negedge lpc_clock);
        lpc_reset = 1'b1;
    endtask

    task automatic test_io_write;
        send(1'b0, 1'b1, 1'b0, 32'h7fe5, 8'h6c, 0, 1'b0, -1, 4'h0, 1'b0, 1);
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes) $display("FAIL io_write_strobes got %0d want %0d", strobes, exp_strobes); else passed++;
        total++;
        if (obs !== {4'b0010, 32'h7fe5, 32'h6c, 4'd1}) $display("FAIL io_write_outputs got %h want %h", obs, {4'b0010, 32'h7fe5, 32'h6c, 4'd1}); else passed++;
    endtask

    task automatic test_io_read;
        send(1'b0, 1'b0, 1'b0, 32'h0080, 8'ha5, 2, 1'b0, -1, 4'h0, 1'b0, 1);
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes) $display("FAIL io_read_strobes got %0d want %0d", strobes, exp_strobes); else passed++;
        total++;
        if (obs !== {4'b0000, 32'h80, 32'ha5, 4'd1}) $display("FAIL io_read_outputs got %h want %h", obs, {4'b0000, 32'h80, 32'ha5, 4'd1}); else passed++;
    endtask

    task automatic test_mem_write;
        send(1'b1, 1'b1, 1'b0, 32'hfffffff0, 8'h12, 1, 1'b0, -1, 4'h0, 1'b0, 1);
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes) $display("FAIL mem_write_strobes got %0d want %0d", strobes, exp_strobes); else passed++;
        total++;
        if (obs !== {4'b0110, 32'hfffffff0, 32'h12, 4'd1}) $display("FAIL mem_write_outputs got %h want %h", obs, {4'b0110, 32'hfffffff0, 32'h12, 4'd1}); else passed++;
    endtask

    task automatic test_abort;
        send(1'b0, 1'b1, 1'b0, 32'h1234, 8'h99, 0, 1'b0, 2, 4'hf, 1'b0, 2);
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes || obs !== expv) $display("FAIL abort_idle got %0d/%h want %0d/%h", strobes, obs, exp_strobes, expv); else passed++;
        send(1'b0, 1'b1, 1'b0, 32'h7fe5, 8'h6c, 0, 1'b0, -1, 4'h0, 1'b0, 1);
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes || obs !== expv) $display("FAIL abort_recover got %0d/%h want %0d/%h", strobes, obs, exp_strobes, expv); else passed++;
        // abort with 0000 is itself a start field: the next nibble is CT/DIR
        send(1'b1, 1'b0, 1'b0, 32'hdeadbeef, 8'h00, 0, 1'b0, 5, 4'h0, 1'b0, 0);
        send(1'b0, 1'b0, 1'b1, 32'h03f8, 8'h5e, 0, 1'b0, -1, 4'h0, 1'b1, 1);
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes || obs !== expv) $display("FAIL abort_restart got %0d/%h want %0d/%h", strobes, obs, exp_strobes, expv); else passed++;
    endtask

    task automatic test_errors;
        send(1'b0, 1'b0, 1'b0, 32'h0060, 8'h77, 1, 1'b1, -1, 4'h0, 1'b0, 2);
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes || obs !== expv) $display("FAIL sync_error got %0d/%h want %0d/%h", strobes, obs, exp_strobes, expv); else passed++;
        drive(1'b0, 4'h0);
        drive(1'b1, 4'b1000);
        repeat (8) drive(1'b1, 4'h0);
        drive(1'b0, 4'h0);
        drive(1'b1, 4'b1110);
        repeat (8) drive(1'b1, 4'($urandom));
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes || obs !== expv) $display("FAIL dma_reserved got %0d/%h want %0d/%h", strobes, obs, exp_strobes, expv); else passed++;
    endtask

    task automatic test_reset_mid;
        drive(1'b0, 4'h0);
        drive(1'b1, 4'b0011);
        drive(1'b1, 4'h4);
        drive(1'b1, 4'h2);
        @(negedge lpc_clock);
        #3 lpc_reset = 1'b0;
        exp_ct = '0; exp_addr = '0; exp_data = '0; exp_size = '0;
        #2;
        total++;
        if (obs !== expv || out_clock_enable !== 1'b0) $display("FAIL reset_mid got %h/%b want %h/0", obs, out_clock_enable, expv); else passed++;
        @(negedge lpc_clock);
        lpc_reset = 1'b1;
        lpc_frame = 1'b1;
        send(1'b0, 1'b1, 1'b0, 32'h0042, 8'h3c, 0, 1'b0, -1, 4'h0, 1'b0, 1);
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes || obs !== expv) $display("FAIL reset_mid_recover got %0d/%h want %0d/%h", strobes, obs, exp_strobes, expv); else passed++;
    endtask

    task automatic test_back_to_back;
        send(1'b1, 1'b0, 1'b0, 32'h000f_fff0, 8'h81, 0, 1'b0, -1, 4'h0, 1'b0, 0);
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes || obs !== expv) $display("FAIL b2b_first got %0d/%h want %0d/%h", strobes, obs, exp_strobes, expv); else passed++;
        send(1'b0, 1'b1, 1'b1, 32'h0cf8, 8'he7, 0, 1'b0, -1, 4'h0, 1'b0, 0);
        @(posedge lpc_clock); #2;
        total++;
        if (strobes !== exp_strobes || obs !== expv) $display("FAIL b2b_second got %0d/%h want %0d/%h", strobes, obs, exp_strobes, expv); else passed++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            send(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 8'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 5) == 0, -1, 4'h0, 1'b0, $urandom_range(0, 2));
            @(posedge lpc_clock); #2;
            total++;
            if (strobes !== exp_strobes || obs !== expv) $display("FAIL random_%0d got %0d/%h want %0d/%h", i, strobes, obs, exp_strobes, expv); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_io_write;
        test_io_read;
        test_mem_write;
        test_abort;
        test_errors;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
